// File: rtl/spi_mem_if.sv
// spi_mem_if: serial bus between an SPI-style controller and spi_mem.
//
// Signals:
//   cs      controller -> memory  chip select, active-low. A frame starts on
//                                 the first clk edge that sees cs low after
//                                 it was high.
//   mosi    controller -> memory  frame bits, LSB first, one per clk.
//   miso    memory -> controller  read data, LSB first, one per clk. It is 0
//                                 whenever no read data is being sent.
//   ready   memory -> controller  one-cycle pulse. Read data starts on miso
//                                 in the cycle after the pulse.
//   op_done memory -> controller  one-cycle pulse when a write frame has been
//                                 committed.
//
// Handshake: there is no back-pressure. The controller owns cs/mosi. It may
// start a new frame only after the previous frame's ready/op_done pulse, and
// for a read only after the eight data cycles have finished. The memory ignores
// cs/mosi while it is committing a write or sending read data.
interface spi_mem_if;
  logic cs;
  logic mosi;
  logic miso;
  logic ready;
  logic op_done;

  modport master (
    output cs,
    output mosi,
    input  miso,
    input  ready,
    input  op_done
  );

  modport slave (
    input  cs,
    input  mosi,
    output miso,
    output ready,
    output op_done
  );
endinterface

// File: rtl/spi_mem.sv
// spi_mem: small byte memory driven by a one-bit-per-clock serial frame.
//
// Frame, LSB first: bit0 = wr, bits[8:1] = addr, bits[16:9] = data.
// A read frame is 9 bits long and a write frame is 17 bits long.
// A write stores data at addr and then pulses op_done.
// A read pulses ready and then shifts mem[addr] out on miso, LSB first.
// Addresses >= DEPTH are not stored on a write and read back as 0x00.
// If cs goes high before the frame is complete, the frame is dropped.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset. Also clears the memory.
//   bus        spi_mem_if.slave (cs, mosi, miso, ready, op_done)
//   dbg_state  current FSM state: 0 IDLE, 1 RX, 2 WRITE, 3 FETCH, 4 TX
//
// DEPTH is expected to be in the range 1..256, because the address is 8 bits.
module spi_mem #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  spi_mem_if.slave   bus,
  output logic [2:0] dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX    = 3'd1,
    WRITE = 3'd2,
    FETCH = 3'd3,
    TX    = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          cs_q;
  logic [4:0]    count, count_nx;
  logic [16:0]   frame, frame_nx;
  logic [7:0]    tx_sr, tx_sr_nx;
  logic          mem_we;
  logic [7:0]    mem [DEPTH];

  logic [7:0]    f_addr;
  logic [7:0]    f_data;
  logic          in_range;
  logic [AW-1:0] mem_idx;

  assign f_addr    = frame[8:1];
  assign f_data    = frame[16:9];
  assign in_range  = 32'(f_addr) < DEPTH;
  assign mem_idx   = f_addr[AW-1:0];
  assign dbg_state = state;

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    frame_nx    = frame;
    tx_sr_nx    = tx_sr;
    mem_we      = 1'b0;
    bus.miso    = 1'b0;
    bus.ready   = 1'b0;
    bus.op_done = 1'b0;

    case (state)
      IDLE: begin
        // mosi is still stale on the edge where the frame starts, so bit 0 is
        // taken on the following edge.
        if (!bus.cs && cs_q) begin
          state_nx = RX;
          count_nx = 5'd0;
        end
      end

      RX: begin
        if (bus.cs) begin
          state_nx = IDLE;
          count_nx = 5'd0;
        end else begin
          frame_nx[count] = bus.mosi;
          count_nx        = count + 5'd1;
          // frame[0] was captured on an earlier edge, so it already holds the
          // wr bit of this frame when count reaches 8 or 16.
          if (count == 5'd8 && !frame[0]) begin
            state_nx = FETCH;
          end else if (count == 5'd16 && frame[0]) begin
            state_nx = WRITE;
          end
        end
      end

      WRITE: begin
        mem_we      = in_range;
        bus.op_done = 1'b1;
        count_nx    = 5'd0;
        state_nx    = IDLE;
      end

      FETCH: begin
        bus.ready = 1'b1;
        tx_sr_nx  = in_range ? mem[mem_idx] : 8'h00;
        count_nx  = 5'd0;
        state_nx  = TX;
      end

      TX: begin
        bus.miso = tx_sr[0];
        tx_sr_nx = {1'b0, tx_sr[7:1]};
        count_nx = count + 5'd1;
        if (count == 5'd7) begin
          count_nx = 5'd0;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        count_nx = 5'd0;
      end
    endcase

    // The outputs stay quiet for the whole time reset is held. This includes
    // the first reset cycle, when the state register has not yet been cleared.
    if (rst) begin
      mem_we      = 1'b0;
      bus.miso    = 1'b0;
      bus.ready   = 1'b0;
      bus.op_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 5'd0;
      cs_q  <= 1'b1;
      frame <= '0;
      tx_sr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      state <= state_nx;
      count <= count_nx;
      cs_q  <= bus.cs;
      frame <= frame_nx;
      tx_sr <= tx_sr_nx;
      if (mem_we) begin
        mem[mem_idx] <= f_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_mem.sv
module tb_spi_mem;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic [2:0]  dbg_state;
  logic [31:0] cyc;

  spi_mem_if bus();

  spi_mem #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // exp_q entry: [31:24] kind (1 = op_done pulse, 2 = ready pulse),
  //              [23:16] expected read byte, [15:0] cycle of the pulse
  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [256];
  int          errors;
  int          checks;
  logic        mon_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] addr);
    return (int'(addr) < DEPTH) ? ref_mem[addr] : 8'h00;
  endfunction

  // ---------------- driver ----------------
  // Sends one frame. abort_at >= 0 raises cs after that many bits.
  // hold_low keeps cs low for that many extra cycles once the frame is complete.
  task automatic send_frame(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                            input int abort_at, input int hold_low);
    logic [16:0] f;
    int          nbits;
    f     = {data, addr, wr};
    nbits = wr ? 17 : 9;
    @(negedge clk);
    bus.cs   = 1'b1;
    bus.mosi = 1'($urandom);
    @(negedge clk);
    bus.cs   = 1'b0;
    bus.mosi = 1'($urandom);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        bus.cs = 1'b1;
        return;
      end
      bus.mosi = f[i];
      if (i == nbits - 1) begin
        if (wr) begin
          if (int'(addr) < DEPTH) ref_mem[addr] = data;
          exp_q.push_back({8'd1, data, cyc[15:0] + 16'd1});
        end else begin
          exp_q.push_back({8'd2, model_read(addr), cyc[15:0] + 16'd1});
        end
      end
    end
    @(negedge clk);
    for (int h = 0; h < hold_low; h++) begin
      bus.mosi = 1'($urandom);
      @(negedge clk);
    end
    bus.cs = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] e;
  logic [7:0]  got;
  logic        aborted;

  initial begin
    mon_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) continue;
      if (bus.ready || bus.op_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got ready=%0b op_done=%0b expected none (cycle %0d)",
                   bus.ready, bus.op_done, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {30'd0, bus.ready, bus.op_done}, {24'd0, e[31:24]});
          check("pulse_cycle", {16'd0, cyc[15:0]}, {16'd0, e[15:0]});
          if (bus.ready) begin
            mon_busy = 1'b1;
            aborted  = 1'b0;
            got      = 8'h00;
            for (int k = 0; k < 8; k++) begin
              @(posedge clk);
              #1;
              if (rst) begin
                aborted = 1'b1;
                break;
              end
              got[k] = bus.miso;
              if (k == 0) check("ready_width", {31'd0, bus.ready}, 32'd0);
            end
            if (!aborted) begin
              check("read_data", {24'd0, got}, {24'd0, e[23:16]});
              @(posedge clk);
              #1;
              if (!rst) check("miso_after_tx", {31'd0, bus.miso}, 32'd0);
            end
            mon_busy = 1'b0;
          end
        end
      end else begin
        check("miso_idle", {31'd0, bus.miso}, 32'd0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         ab;
    int         hold;

    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_op_done", {31'd0, bus.op_done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // write then read back
    send_frame(1'b1, 8'h05, 8'hA7, -1, 0); wait_drain();
    send_frame(1'b0, 8'h05, 8'h00, -1, 0); wait_drain();
    // out-of-range addresses, with no aliasing onto address 0
    send_frame(1'b1, 8'h40, 8'hFF, -1, 0); wait_drain();
    send_frame(1'b0, 8'h40, 8'h00, -1, 0); wait_drain();
    send_frame(1'b0, 8'h00, 8'h00, -1, 0); wait_drain();
    send_frame(1'b1, 8'h20, 8'h99, -1, 0); wait_drain();
    send_frame(1'b0, 8'h20, 8'h00, -1, 0); wait_drain();
    // abort after 5 bits, then check that the next frames still decode
    send_frame(1'b1, 8'h03, 8'h99, 5, 0); wait_drain();
    send_frame(1'b0, 8'h03, 8'h00, -1, 0); wait_drain();
    send_frame(1'b0, 8'h05, 8'h00, -1, 0); wait_drain();
    // back-to-back frames to the top address, with cs held low afterwards
    send_frame(1'b1, 8'h1F, 8'h3C, -1, 4); wait_drain();
    send_frame(1'b0, 8'h1F, 8'h00, -1, 12); wait_drain();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      data = 8'($urandom);
      ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, wr ? 16 : 8) : -1;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      send_frame(wr, addr, data, ab, hold);
      wait_drain();
    end

    // reset in the middle of sending read data
    send_frame(1'b1, 8'h02, 8'h5A, -1, 0); wait_drain();
    send_frame(1'b0, 8'h02, 8'h00, -1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midtx_rst_miso", {31'd0, bus.miso}, 32'd0);
    check("midtx_rst_ready", {31'd0, bus.ready}, 32'd0);
    check("midtx_rst_op_done", {31'd0, bus.op_done}, 32'd0);
    check("midtx_rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_rst_state", {29'd0, dbg_state}, 32'd0);
    for (int a = 0; a < DEPTH; a++) begin
      send_frame(1'b0, 8'(a), 8'h00, -1, 0);
      wait_drain();
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_mem.md
SPI_MEM -- requirements
Module: spi_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of 8-bit storage locations; the valid address range is 0..DEPTH-1.
REQ-002 SHALL have port clk, input, 1 bit: clock; all logic updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port cs, input, 1 bit: chip select, active-low, driven by the SPI controller.
REQ-005 SHALL have port mosi, input, 1 bit: serial data from the controller, LSB first, one bit per clk.
REQ-006 SHALL have port miso, output, 1 bit: serial read data to the controller, LSB first, one bit per clk.
REQ-007 SHALL have port ready, output, 1 bit: one-cycle pulse meaning read data follows on miso from the next cycle.
REQ-008 SHALL have port op_done, output, 1 bit: one-cycle pulse meaning the write frame has completed.

Function
REQ-009 SHALL use states IDLE, RX, WRITE, FETCH and TX.
REQ-010 SHALL register cs every cycle into cs_q; a frame start is an edge where cs==0 and cs_q==1.
REQ-011 SHALL, in IDLE on a frame-start edge, enter RX with bit count 0 and SHALL NOT sample mosi on that edge (mosi is stale on that edge).
REQ-012 SHALL, in RX, shift mosi into a 17-bit frame register at bit index count on each edge where cs==0, then increment count.
REQ-013 SHALL define the frame as bit0 = wr, bits[8:1] = addr[7:0], bits[16:9] = data[7:0].
REQ-014 SHALL, in RX, go RX->FETCH on the edge that samples bit 8 when bit0==0 (9-bit read frame).
REQ-015 SHALL, in RX, go RX->WRITE on the edge that samples bit 16 when bit0==1 (17-bit write frame).
REQ-016 SHALL, on an RX edge where cs==1 before the frame is complete, abort to IDLE with no memory write and no pulses.
REQ-017 SHALL, in WRITE, store data at mem[addr] if addr<DEPTH, drive op_done=1 for exactly one cycle, then return to IDLE.
REQ-018 SHALL, in WRITE with addr>=DEPTH, leave memory unchanged and still pulse op_done.
REQ-019 SHALL, in FETCH, load a TX shift register with mem[addr] (0x00 if addr>=DEPTH), drive ready=1 for exactly one cycle (cycle T), then enter TX.
REQ-020 SHALL drive miso = data[k] during cycle T+1+k for k = 0..7.
REQ-021 SHALL, after the cycle carrying data[7], drive miso=0 and return to IDLE.
REQ-022 SHALL ignore cs and mosi in WRITE, FETCH and TX.
REQ-023 SHALL require a new high->low cs transition to start the next frame; a cs held low after a frame SHALL NOT retrigger.
REQ-024 SHALL hold miso=0 in every state except TX.
REQ-025 SHALL give a write frame a latency of op_done one cycle after the edge sampling bit 16.
REQ-026 SHALL give a read frame a latency of ready one cycle after the edge sampling bit 8.

Reset
REQ-027 SHALL, while rst==1, force state=IDLE, count=0, cs_q=1, miso=0, ready=0 and op_done=0.
REQ-028 SHALL, while rst==1, clear all DEPTH memory locations to 0x00.
REQ-029 SHALL give rst priority over all activity, including assertion mid-frame or mid-TX; after rst deasserts, a new cs falling edge is required to start a frame.

Verification
REQ-030 SHALL cover a write: frame wr=1, addr=0x05, data=0xA7 -> op_done single pulse one cycle after bit 16; mem[5]==0xA7.
REQ-031 SHALL cover a read-back: read frame addr=0x05 after the write above -> ready pulse one cycle after bit 8; miso serialises 1,1,1,0,0,1,0,1 (0xA7 LSB first) in cycles T+1..T+8, then 0.
REQ-032 SHALL cover out-of-range addresses: write addr=0x40, data=0xFF -> op_done pulses with memory unchanged; read addr=0x40 -> ready pulses and miso sends 0x00.
REQ-033 SHALL cover abort: cs raised after 5 bits of a write frame to addr=0x03 -> no op_done, mem[3] unchanged, next frame decodes correctly.
REQ-034 SHALL cover reset mid-TX: rst asserted at T+3 of a read -> miso=0 and ready=0 the next cycle, memory all 0x00, state IDLE.
REQ-035 SHALL cover back-to-back controller traffic: write then read to addr=0x1F with data 0x3C -> controller dout==0x3C, done asserted, with no retrigger while cs stays low.
